drp_adc_responder: RTL and testbench
====================================

Name: drp_adc_responder

Overview:
- DRP target (responder) that models the XADC dynamic reconfiguration port as seen by a DRP master state machine.
- Holds a 128 x 16 register space:
  - 0x00-0x3F: read-only status, filled from a sample input stream.
  - 0x40-0x7F: read/write configuration.
- Generates BUSY, CHANNEL, EOC and EOS.
- Used as a soft ADC front end and as the bench target for DRP masters in the oscilloscope datapath.

Parameters:
- RD_LATENCY, 4: cycles from the DEN cycle to the DRDY cycle; legal range 1..15.
- BUSY_CYCLES, 16: BUSY length after reset release and after a config write to 0x40-0x42; legal range 1..255.

Ports:
- DCLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- DEN  in  1  DRP enable; single-cycle strobe
- DWE  in  1  DRP write enable; sampled only when DEN=1
- DADDR  in  7  DRP address
- DI  in  16  DRP write data
- DO  out  16  DRP read data; valid only while DRDY=1, 0 otherwise
- DRDY  out  1  one-cycle completion pulse
- SAMPLE_VALID  in  1  a new conversion result is present
- SAMPLE_CH  in  5  channel number; status address = {2'b00, SAMPLE_CH}
- SAMPLE_DATA  in  16  conversion result; 12-bit code left-justified
- SAMPLE_LAST  in  1  this sample ends the sequence
- BUSY  out  1  calibration or reconfiguration in progress
- CHANNEL  out  5  channel of the last stored sample
- EOC  out  1  one-cycle end-of-conversion pulse
- EOS  out  1  one-cycle end-of-sequence pulse

Behaviour:
- Clock and reset:
  - One clock domain, DCLK. RESET is asynchronous and active-high.
  - All state uses async clear on RESET.
- Reset values:
  - DO=0, DRDY=0, EOC=0, EOS=0, CHANNEL=0.
  - BUSY=1, all 128 registers = 0x0000.
- BUSY after reset: stays 1 for exactly BUSY_CYCLES DCLK cycles after RESET deasserts, then 0.
- DRP FSM states: IDLE, WAIT, RESP.
  - IDLE, DEN=1: capture DADDR, DWE and DI. Snapshot the read data for DADDR from the pre-update contents. Load the counter with RD_LATENCY-1. Next state is WAIT, or RESP when RD_LATENCY=1.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: DRDY=1 for one cycle. On a read, DO = snapshot. On a write, DO = 0. Next state is IDLE.
  - Result: DRDY rises exactly RD_LATENCY cycles after the DEN cycle.
  - DEN in RESP, or in WAIT, is ignored: no second DRDY and no state change.
  - A new DEN is accepted in IDLE on the cycle after DRDY.
- Writes: committed on the RESP cycle.
  - DADDR 0x40-0x7F: register <= DI.
  - DADDR 0x00-0x3F: write discarded; DRDY still pulses.
  - Write to 0x40, 0x41 or 0x42: BUSY <= 1 from the cycle after RESP for BUSY_CYCLES cycles. The counter restarts if another such write lands while BUSY.
- Sample path: when SAMPLE_VALID=1 and BUSY=0:
  - Status register {2'b00, SAMPLE_CH} <= SAMPLE_DATA.
  - Next cycle: EOC=1 and CHANNEL=SAMPLE_CH.
  - EOS=1 in the same cycle as EOC if SAMPLE_LAST=1.
  - Samples with BUSY=1 are dropped: no register update, no EOC or EOS.
- Simultaneous events:
  - A sample write and a DEN read of the same address in one cycle: the read returns the old value.
  - A sample arriving during WAIT does not alter the snapshot.
  - Back-to-back SAMPLE_VALID gives back-to-back EOC pulses.
- Addresses 0x20-0x3F: not written by samples; they read 0x0000 unless reset state changes.
- Reset mid-transaction: FSM returns to IDLE. The pending DRDY is never issued and a pending write is not committed.

Optional Feature:
- Macro: DRP_ERR_CHECK_EN.
- When defined:
  - Adds output port DRP_ERR (1 bit, reset 0). It is sticky.
  - DRP_ERR sets on DEN=1 while the FSM is not IDLE.
  - DRP_ERR sets on DEN=1 with DWE=1 and DADDR < 0x40.
  - DRP_ERR clears only on RESET or on a committed DRP write to 0x7F; the write also stores DI as usual.
- When undefined: no DRP_ERR port; those conditions are silently ignored as described above.

Test Plan:
- Reset, then wait: BUSY=1 for 16 cycles after RESET falls, then 0. A read of 0x40 returns DO=0x0000 with DRDY exactly 4 cycles after DEN.
- SAMPLE_VALID with CH=0x16, DATA=0xABC0 and SAMPLE_LAST=0, then DRP read 0x16: EOC=1 and CHANNEL=0x16 the next cycle, EOS=0. The read returns 0xABC0.
- Write 0x40 <= 0x1234 then read it back: DO=0x1234. BUSY is high for 16 cycles starting the cycle after the write DRDY. SAMPLE_VALID during that window causes no EOC and the status register is unchanged.
- Write 0x05 <= 0xFFFF: DRDY pulses. A read of 0x05 still returns its prior value. With DRP_ERR_CHECK_EN, DRP_ERR=1; a later write to 0x7F clears it.
- Read 0x01 and pulse SAMPLE_VALID with CH=1, DATA=0x5550 in the same cycle: DO=old value (0x0000). A second read returns 0x5550. A DEN during WAIT produces only one DRDY.
- Assert RESET during WAIT of a write to 0x41 <= 0x00FF: no DRDY. After reset, a read of 0x41 returns 0x0000.

Source files
------------

// File: rtl/drp_adc_responder.sv
`default_nettype none
// ============================================================================
//  Module      : drp_adc_responder
//  Description : DRP responder modelling the XADC dynamic reconfiguration
//                port. It holds a 128 x 16 register space: 0x00-0x3F is
//                read-only status filled from a sample stream, and 0x40-0x7F
//                is read/write configuration. It also generates BUSY,
//                CHANNEL, EOC and EOS.
//  Optional    : define DRP_ERR_CHECK_EN to add the sticky DRP_ERR output.
//  Ports       : DCLK, RESET (async, active-high)
//                DEN/DWE/DADDR/DI -> DO/DRDY          DRP access
//                SAMPLE_VALID/CH/DATA/LAST            conversion results in
//                BUSY, CHANNEL, EOC, EOS              ADC status out
//                DRP_ERR (optional)                   protocol error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module drp_adc_responder #(
    parameter int RD_LATENCY  = 4,   // DEN cycle to DRDY cycle, 1..15
    parameter int BUSY_CYCLES = 16   // BUSY length, 1..255
) (
    input  logic        DCLK,
    input  logic        RESET,
    input  logic        DEN,
    input  logic        DWE,
    input  logic [6:0]  DADDR,
    input  logic [15:0] DI,
    output logic [15:0] DO,
    output logic        DRDY,
    input  logic        SAMPLE_VALID,
    input  logic [4:0]  SAMPLE_CH,
    input  logic [15:0] SAMPLE_DATA,
    input  logic        SAMPLE_LAST,
    output logic        BUSY,
    output logic [4:0]  CHANNEL,
    output logic        EOC,
    output logic        EOS
`ifdef DRP_ERR_CHECK_EN
    ,
    output logic        DRP_ERR
`endif
);

    localparam logic [3:0] c_LAT_LOAD  = 4'(RD_LATENCY - 1);
    localparam logic [7:0] c_BUSY_LOAD = 8'(BUSY_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Captured transaction
    logic [6:0]  r_addr;
    logic        r_we;
    logic [15:0] r_di;
    logic [15:0] r_snap;
    logic [3:0]  r_lat_cnt;

    // Register space. Only 0x00-0x1F of the status half can ever be written
    // (by samples), so 0x20-0x3F is not stored and always reads zero.
    logic [15:0] r_status [32];
    logic [15:0] r_cfg    [64];

    logic [7:0]  r_busy_cnt;
    logic        r_eoc;
    logic        r_eos;
    logic [4:0]  r_channel;

    logic [15:0] w_rd_data;
    logic        w_commit;
    logic        w_sample_acc;
    logic        w_busy_trig;

    // ------------------------------------------------------------------
    // Read mux over the current (pre-update) register contents
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = 16'h0000;
        if (DADDR[6]) begin
            w_rd_data = r_cfg[DADDR[5:0]];
        end else if (!DADDR[5]) begin
            w_rd_data = r_status[DADDR[4:0]];
        end
    end

    assign w_commit     = (r_state == ST_RESP) && r_we;
    assign w_busy_trig  = w_commit && (r_addr inside {7'h40, 7'h41, 7'h42});
    assign BUSY         = (r_busy_cnt != 8'd0);
    assign w_sample_acc = SAMPLE_VALID && !BUSY;

    // ------------------------------------------------------------------
    // DRP FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // DRP FSM: next state and outputs. DEN outside IDLE is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        DRDY        = 1'b0;
        DO          = 16'h0000;
        case (r_state)
            ST_IDLE: begin
                if (DEN) begin
                    w_state_nxt = (RD_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter holds the cycles still to wait; leave on the last
                if (r_lat_cnt <= 4'd1) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                DRDY        = 1'b1;
                DO          = r_we ? 16'h0000 : r_snap;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction capture and latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            r_addr    <= 7'd0;
            r_we      <= 1'b0;
            r_di      <= 16'h0000;
            r_snap    <= 16'h0000;
            r_lat_cnt <= 4'd0;
        end else begin
            if (r_state == ST_IDLE && DEN) begin
                r_addr    <= DADDR;
                r_we      <= DWE;
                r_di      <= DI;
                r_snap    <= w_rd_data;
                r_lat_cnt <= c_LAT_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers: written on the RESP cycle only
    // ------------------------------------------------------------------
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 64; i++) begin
                r_cfg[i] <= 16'h0000;
            end
        end else if (w_commit && r_addr[6]) begin
            r_cfg[r_addr[5:0]] <= r_di;
        end
    end

    // ------------------------------------------------------------------
    // Status registers and conversion flags
    // ------------------------------------------------------------------
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) begin
                r_status[i] <= 16'h0000;
            end
            r_eoc     <= 1'b0;
            r_eos     <= 1'b0;
            r_channel <= 5'd0;
        end else begin
            r_eoc <= w_sample_acc;
            r_eos <= w_sample_acc && SAMPLE_LAST;
            if (w_sample_acc) begin
                r_status[SAMPLE_CH] <= SAMPLE_DATA;
                r_channel           <= SAMPLE_CH;
            end
        end
    end

    assign EOC     = r_eoc;
    assign EOS     = r_eos;
    assign CHANNEL = r_channel;

    // ------------------------------------------------------------------
    // BUSY: loaded at reset and on a reconfiguring write, counts to zero.
    // A new trigger while counting restarts the window.
    // ------------------------------------------------------------------
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            r_busy_cnt <= c_BUSY_LOAD;
        end else if (w_busy_trig) begin
            r_busy_cnt <= c_BUSY_LOAD;
        end else if (r_busy_cnt != 8'd0) begin
            r_busy_cnt <= r_busy_cnt - 8'd1;
        end
    end

`ifdef DRP_ERR_CHECK_EN
    // ------------------------------------------------------------------
    // Sticky protocol error. A fresh error wins over a same-cycle clear.
    // ------------------------------------------------------------------
    logic r_err;

    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            r_err <= 1'b0;
        end else if (DEN && ((r_state != ST_IDLE) || (DWE && !DADDR[6]))) begin
            r_err <= 1'b1;
        end else if (w_commit && (r_addr == 7'h7F)) begin
            r_err <= 1'b0;
        end
    end

    assign DRP_ERR = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_drp_adc_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_drp_adc_responder
//  Description : Self-checking bench for drp_adc_responder (default
//                parameters RD_LATENCY=4, BUSY_CYCLES=16). Directed
//                sequences for reset, BUSY, sample path, collisions and
//                reset mid-transaction, plus a table of DRP accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_drp_adc_responder;

    logic        DCLK = 1'b0;
    logic        RESET;
    logic        DEN;
    logic        DWE;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DRDY;
    logic        SAMPLE_VALID;
    logic [4:0]  SAMPLE_CH;
    logic [15:0] SAMPLE_DATA;
    logic        SAMPLE_LAST;
    logic        BUSY;
    logic [4:0]  CHANNEL;
    logic        EOC;
    logic        EOS;
`ifdef DRP_ERR_CHECK_EN
    logic        DRP_ERR;
`endif

    int checks = 0;
    int errors = 0;

    always #5 DCLK = ~DCLK;

    drp_adc_responder dut (
        .DCLK         (DCLK),
        .RESET        (RESET),
        .DEN          (DEN),
        .DWE          (DWE),
        .DADDR        (DADDR),
        .DI           (DI),
        .DO           (DO),
        .DRDY         (DRDY),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_CH    (SAMPLE_CH),
        .SAMPLE_DATA  (SAMPLE_DATA),
        .SAMPLE_LAST  (SAMPLE_LAST),
        .BUSY         (BUSY),
        .CHANNEL      (CHANNEL),
        .EOC          (EOC),
        .EOS          (EOS)
`ifdef DRP_ERR_CHECK_EN
        ,
        .DRP_ERR      (DRP_ERR)
`endif
    );

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
        logic [15:0] exp_do;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    // One DRP access; returns the DO seen with DRDY and the DEN->DRDY latency
    task automatic drp_xfer(input logic we, input logic [6:0] a, input logic [15:0] d,
                            output logic [15:0] q, output int lat);
        logic leak;
        DEN = 1'b1; DWE = we; DADDR = a; DI = d;
        tick();
        DEN = 1'b0; DWE = 1'b0;
        lat  = 1;
        leak = 1'b0;
        while (!DRDY && lat < 20) begin
            if (DO != 16'h0000) leak = 1'b1;
            tick();
            lat++;
        end
        q = DO;
        tick();
        chk("drdy_one_cycle", {31'd0, DRDY}, 32'd0);
        chk("do_zero_when_idle", {31'd0, leak}, 32'd0);
    endtask

    task automatic sample(input logic [4:0] ch, input logic [15:0] d, input logic last);
        SAMPLE_VALID = 1'b1; SAMPLE_CH = ch; SAMPLE_DATA = d; SAMPLE_LAST = last;
        tick();
        SAMPLE_VALID = 1'b0; SAMPLE_LAST = 1'b0;
    endtask

    initial begin
        logic [15:0] q;
        int          lat;
        int          n;
        int          drdy_cnt;
        int          drdy_at;
        logic [15:0] drdy_do;
        logic        eoc_seen;

        // {we, addr, di, expected DO}
        vecs[0]  = '{1'b1, 7'h25, 16'h9999, 16'h0000};
        vecs[1]  = '{1'b0, 7'h25, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 7'h50, 16'hBEEF, 16'h0000};
        vecs[3]  = '{1'b0, 7'h50, 16'h0000, 16'hBEEF};
        vecs[4]  = '{1'b1, 7'h43, 16'hA5A5, 16'h0000};
        vecs[5]  = '{1'b0, 7'h43, 16'h0000, 16'hA5A5};
        vecs[6]  = '{1'b0, 7'h44, 16'h0000, 16'h0000};
        vecs[7]  = '{1'b0, 7'h16, 16'h0000, 16'hABC0};
        vecs[8]  = '{1'b0, 7'h05, 16'h0000, 16'h7770};
        vecs[9]  = '{1'b0, 7'h40, 16'h0000, 16'h1234};
        vecs[10] = '{1'b1, 7'h7F, 16'h0F0F, 16'h0000};
        vecs[11] = '{1'b0, 7'h7F, 16'h0000, 16'h0F0F};

        RESET = 1'b1; DEN = 1'b0; DWE = 1'b0; DADDR = '0; DI = '0;
        SAMPLE_VALID = 1'b0; SAMPLE_CH = '0; SAMPLE_DATA = '0; SAMPLE_LAST = 1'b0;
        repeat (3) tick();

        // ---------------- reset state ----------------
        chk("rst_do", {16'd0, DO}, 32'h0);
        chk("rst_drdy", {31'd0, DRDY}, 32'h0);
        chk("rst_eoc_eos", {30'd0, EOC, EOS}, 32'h0);
        chk("rst_channel", {27'd0, CHANNEL}, 32'h0);
        chk("rst_busy", {31'd0, BUSY}, 32'h1);
`ifdef DRP_ERR_CHECK_EN
        chk("rst_drp_err", {31'd0, DRP_ERR}, 32'h0);
`endif

        // BUSY stays high for 16 cycles after RESET falls
        RESET = 1'b0;
        n = 0;
        while (BUSY && n < 300) begin
            n++;
            tick();
        end
        chk("busy_after_reset_len", n, 32'd16);

        drp_xfer(1'b0, 7'h40, 16'h0, q, lat);
        chk("rd40_data", {16'd0, q}, 32'h0000);
        chk("rd40_latency", lat, 32'd4);

        // ---------------- sample path ----------------
        sample(5'h16, 16'hABC0, 1'b0);
        chk("smp16_eoc", {31'd0, EOC}, 32'h1);
        chk("smp16_eos", {31'd0, EOS}, 32'h0);
        chk("smp16_channel", {27'd0, CHANNEL}, 32'h16);
        tick();
        chk("smp16_eoc_pulse", {31'd0, EOC}, 32'h0);
        drp_xfer(1'b0, 7'h16, 16'h0, q, lat);
        chk("rd16_data", {16'd0, q}, 32'hABC0);

        // back-to-back samples, second one ends the sequence
        SAMPLE_VALID = 1'b1; SAMPLE_CH = 5'h02; SAMPLE_DATA = 16'h2220; SAMPLE_LAST = 1'b0;
        tick();
        chk("b2b_eoc1", {26'd0, EOC, CHANNEL}, {26'd0, 1'b1, 5'h02});
        chk("b2b_eos1", {31'd0, EOS}, 32'h0);
        SAMPLE_CH = 5'h03; SAMPLE_DATA = 16'h3330; SAMPLE_LAST = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0; SAMPLE_LAST = 1'b0;
        chk("b2b_eoc2", {26'd0, EOC, CHANNEL}, {26'd0, 1'b1, 5'h03});
        chk("b2b_eos2", {31'd0, EOS}, 32'h1);
        sample(5'h05, 16'h7770, 1'b0);

        // ---------------- config write and BUSY window ----------------
        drp_xfer(1'b1, 7'h40, 16'h1234, q, lat);
        chk("wr40_do_zero", {16'd0, q}, 32'h0);
        chk("wr40_latency", lat, 32'd4);
        n = 0;
        eoc_seen = 1'b0;
        while (BUSY && n < 300) begin
            SAMPLE_VALID = (n == 0 || n == 7);
            SAMPLE_CH    = 5'h16;
            SAMPLE_DATA  = 16'h1111;
            if (EOC) eoc_seen = 1'b1;
            n++;
            tick();
        end
        SAMPLE_VALID = 1'b0;
        if (EOC) eoc_seen = 1'b1;
        chk("busy_after_wr_len", n, 32'd16);
        chk("busy_drops_samples", {31'd0, eoc_seen}, 32'h0);
        drp_xfer(1'b0, 7'h40, 16'h0, q, lat);
        chk("rd40_after_wr", {16'd0, q}, 32'h1234);
        drp_xfer(1'b0, 7'h16, 16'h0, q, lat);
        chk("rd16_unchanged", {16'd0, q}, 32'hABC0);

        // ---------------- write to read-only status ----------------
        drp_xfer(1'b1, 7'h05, 16'hFFFF, q, lat);
        chk("wr05_latency", lat, 32'd4);
        drp_xfer(1'b0, 7'h05, 16'h0, q, lat);
        chk("rd05_unchanged", {16'd0, q}, 32'h7770);
`ifdef DRP_ERR_CHECK_EN
        chk("err_after_ro_write", {31'd0, DRP_ERR}, 32'h1);
`endif

        // ---------------- read/sample collision and DEN during WAIT ----------------
        DEN = 1'b1; DWE = 1'b0; DADDR = 7'h01;
        SAMPLE_VALID = 1'b1; SAMPLE_CH = 5'h01; SAMPLE_DATA = 16'h5550;
        drdy_cnt = 0; drdy_at = 0; drdy_do = 16'hDEAD;
        for (int k = 1; k <= 10; k++) begin
            tick();
            DEN = (k == 2);
            DADDR = (k == 2) ? 7'h40 : 7'h01;
            SAMPLE_VALID = 1'b0;
            if (k == 1) chk("collide_eoc", {31'd0, EOC}, 32'h1);
            if (DRDY) begin
                drdy_cnt++;
                if (drdy_cnt == 1) begin
                    drdy_at = k;
                    drdy_do = DO;
                end
            end
        end
        chk("collide_single_drdy", drdy_cnt, 32'd1);
        chk("collide_latency", drdy_at, 32'd4);
        chk("collide_old_value", {16'd0, drdy_do}, 32'h0000);
        drp_xfer(1'b0, 7'h01, 16'h0, q, lat);
        chk("rd01_new_value", {16'd0, q}, 32'h5550);

        // ---------------- table of DRP accesses ----------------
        for (int i = 0; i < 12; i++) begin
            drp_xfer(vecs[i].we, vecs[i].addr, vecs[i].di, q, lat);
            chk($sformatf("vec%0d_do", i), {16'd0, q}, {16'd0, vecs[i].exp_do});
            chk($sformatf("vec%0d_latency", i), lat, 32'd4);
        end
`ifdef DRP_ERR_CHECK_EN
        chk("err_cleared_by_7f", {31'd0, DRP_ERR}, 32'h0);
`endif

        // ---------------- reset during WAIT of a write ----------------
        DEN = 1'b1; DWE = 1'b1; DADDR = 7'h41; DI = 16'h00FF;
        tick();
        DEN = 1'b0; DWE = 1'b0;
        tick();
        RESET = 1'b1;
        drdy_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (DRDY) drdy_cnt++;
            tick();
        end
        RESET = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (DRDY) drdy_cnt++;
            tick();
        end
        chk("rst_mid_no_drdy", drdy_cnt, 32'd0);
        drp_xfer(1'b0, 7'h41, 16'h0, q, lat);
        chk("rd41_after_reset", {16'd0, q}, 32'h0000);
        drp_xfer(1'b0, 7'h40, 16'h0, q, lat);
        chk("rd40_after_reset", {16'd0, q}, 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
